// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared cache-bus types plus arbiter state encoding.
package cbus_rr_arbiter_pkg;

    typedef enum logic [7:0] {
        MLEN1 = 8'd0,
        MLEN2 = 8'd1,
        MLEN4 = 8'd3,
        MLEN8 = 8'd7
    } mlen_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    // 151 bits: request held stable for the burst except strb/data
    typedef struct packed {
        logic        valid;
        logic        we;
        logic [63:0] addr;
        mlen_t       len;
        msize_t      size;
        logic [1:0]  burst;
        logic [7:0]  strb;
        logic [63:0] data;
    } cbus_req_t;

    // 66 bits
    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cbus_rr_arbiter_pick.sv
// Round-robin priority encoder: first valid index after last_idx, wrapping.
module rr_pick #(
    parameter int N_MASTERS = 2
) (
    input  logic [N_MASTERS-1:0]         valid_i,
    input  logic [$clog2(N_MASTERS)-1:0] last_idx_i,
    output logic                         any_o,
    output logic [$clog2(N_MASTERS)-1:0] pick_idx_o
);
    localparam int IDX_W = $clog2(N_MASTERS);

    logic [IDX_W:0] cand;

    // Scan farthest offset first so the nearest valid candidate overwrites it.
    always_comb begin
        any_o      = 1'b0;
        pick_idx_o = '0;
        cand       = '0;
        for (int k = N_MASTERS; k >= 1; k--) begin
            cand = {1'b0, last_idx_i} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_MASTERS)) begin
                cand = cand - (IDX_W+1)'(N_MASTERS);
            end
            if (valid_i[cand[IDX_W-1:0]]) begin
                any_o      = 1'b1;
                pick_idx_o = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// Round-robin cache-bus arbiter; grant is locked from acceptance until ready && last.
module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  cbus_req_t  [N_MASTERS-1:0]   ireqs,
    output cbus_resp_t [N_MASTERS-1:0]   iresps,
    output cbus_req_t                    oreq,
    input  cbus_resp_t                   oresp
);
    localparam int IDX_W = $clog2(N_MASTERS);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] last_idx_q, last_idx_d;
    logic [N_MASTERS-1:0] req_valid;
    logic             any;
    logic [IDX_W-1:0] pick_idx;

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_valid
        assign req_valid[i] = ireqs[i].valid;
    end

    rr_pick #(.N_MASTERS(N_MASTERS)) u_pick (
        .valid_i    (req_valid),
        .last_idx_i (last_idx_q),
        .any_o      (any),
        .pick_idx_o (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            grant_idx_q <= '0;
            last_idx_q  <= IDX_W'(N_MASTERS - 1);
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            last_idx_q  <= last_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        last_idx_d  = last_idx_q;
        case (state_q)
            ARB_IDLE: begin
                if (any) begin
                    grant_idx_d = pick_idx;
                    state_d     = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // Release on the final beat even if the master already dropped valid.
                if (oresp.ready && oresp.last) begin
                    last_idx_d = grant_idx_q;
                    state_d    = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        oreq   = '0;
        iresps = '0;
        if (!reset && state_q == ARB_BUSY) begin
            oreq                = ireqs[grant_idx_q];
            iresps[grant_idx_q] = oresp;
        end
    end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Directed self-checking bench for cbus_rr_arbiter with two masters.
module tb_cbus_rr_arbiter;
    import cbus_rr_arbiter_pkg::*;

    localparam int N = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    cbus_req_t  [N-1:0]   ireqs;
    cbus_resp_t [N-1:0]   iresps;
    cbus_req_t            oreq;
    cbus_resp_t           oresp;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cbus_rr_arbiter #(.N_MASTERS(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .ireqs  (ireqs),
        .iresps (iresps),
        .oreq   (oreq),
        .oresp  (oresp)
    );

    function automatic cbus_req_t mk_req(logic v, logic we, logic [63:0] addr, mlen_t len,
                                         msize_t size, logic [7:0] strb, logic [63:0] data);
        cbus_req_t r;
        r.valid = v;   r.we   = we;   r.addr = addr; r.len  = len;
        r.size  = size; r.burst = 2'b01; r.strb = strb; r.data = data;
        return r;
    endfunction

    function automatic cbus_resp_t mk_resp(logic rdy, logic last, logic [63:0] data);
        cbus_resp_t r;
        r.ready = rdy; r.last = last; r.data = data;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ireqs = '0;
        oresp = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ireqs = '0;
        oresp = '0;
        tick();
        ireqs[0] = mk_req(1'b1, 1'b0, 64'h40, MLEN1, MSIZE8, 8'h00, 64'h0);
        oresp    = mk_resp(1'b1, 1'b1, 64'hDEAD);
        tick();
        @(negedge clk);
        n_checks++;
        if (oreq !== '0) begin
            n_fail++; $display("FAIL reset_oreq: got %h want 0", oreq);
        end
        n_checks++;
        if (iresps !== '0) begin
            n_fail++; $display("FAIL reset_iresps: got %h want 0", iresps);
        end
        reset = 1'b0;
        ireqs = '0;
        oresp = '0;
        tick();
        @(negedge clk);
        n_checks++;
        if (oreq !== '0) begin
            n_fail++; $display("FAIL reset_idle_oreq: got %h want 0", oreq);
        end
    endtask

    task automatic test_read_burst();
        cbus_req_t  r0;
        cbus_resp_t rs;
        r0 = mk_req(1'b1, 1'b0, 64'h8000_0000, MLEN4, MSIZE8, 8'h00, 64'h0);
        do_reset();
        ireqs[0] = r0;
        @(negedge clk);
        n_checks++;
        if (oreq.valid !== 1'b0) begin
            n_fail++; $display("FAIL rd_not_yet: got %b want 0", oreq.valid);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (oreq !== r0) begin
            n_fail++; $display("FAIL rd_oreq: got %h want %h", oreq, r0);
        end
        for (int b = 0; b < 4; b++) begin
            tick();
            rs = mk_resp(1'b1, b == 3, 64'hA0 + 64'(b));
            oresp = rs;
            @(negedge clk);
            n_checks++;
            if (iresps[0] !== rs) begin
                n_fail++; $display("FAIL rd_beat%0d_m0: got %h want %h", b, iresps[0], rs);
            end
            n_checks++;
            if (iresps[1] !== '0) begin
                n_fail++; $display("FAIL rd_beat%0d_m1: got %h want 0", b, iresps[1]);
            end
        end
        tick();
        ireqs = '0;
        oresp = mk_resp(1'b1, 1'b0, 64'hBEEF);
        @(negedge clk);
        n_checks++;
        if (iresps[0] !== '0 || oreq !== '0) begin
            n_fail++; $display("FAIL rd_idle_after: iresps %h oreq %h want 0", iresps[0], oreq);
        end
        tick();
        oresp = '0;
    endtask

    task automatic test_round_robin();
        cbus_req_t  r0, r1;
        cbus_resp_t rs;
        int         exp_m;
        r0 = mk_req(1'b1, 1'b0, 64'h1000, MLEN1, MSIZE8, 8'h00, 64'h0);
        r1 = mk_req(1'b1, 1'b0, 64'h2000, MLEN1, MSIZE8, 8'h00, 64'h0);
        do_reset();
        ireqs[0] = r0;
        ireqs[1] = r1;
        for (int r = 0; r < 6; r++) begin
            exp_m = r % 2;
            @(negedge clk);
            n_checks++;
            if (oreq.valid !== 1'b0) begin
                n_fail++; $display("FAIL rr_idle_r%0d: got %b want 0", r, oreq.valid);
            end
            tick();
            rs = mk_resp(1'b1, 1'b1, 64'(r));
            oresp = rs;
            @(negedge clk);
            n_checks++;
            if (oreq.addr !== (exp_m == 1 ? 64'h2000 : 64'h1000)) begin
                n_fail++; $display("FAIL rr_grant_r%0d: got addr %h want master %0d", r, oreq.addr, exp_m);
            end
            n_checks++;
            if (iresps[exp_m] !== rs) begin
                n_fail++; $display("FAIL rr_resp_r%0d: got %h want %h", r, iresps[exp_m], rs);
            end
            n_checks++;
            if (iresps[1-exp_m] !== '0) begin
                n_fail++; $display("FAIL rr_other_r%0d: got %h want 0", r, iresps[1-exp_m]);
            end
            tick();
            oresp = '0;
        end
        ireqs = '0;
    endtask

    task automatic test_back_to_back_write();
        cbus_req_t r0, r1;
        r0 = mk_req(1'b1, 1'b0, 64'h3000, MLEN1, MSIZE8, 8'h00, 64'h0);
        r1 = mk_req(1'b1, 1'b1, 64'h4000, MLEN2, MSIZE8, 8'hff, 64'h1111);
        do_reset();
        ireqs[1] = r1;
        tick();
        ireqs[0] = r0;
        @(negedge clk);
        n_checks++;
        if (oreq !== r1) begin
            n_fail++; $display("FAIL wr_grant_m1: got %h want %h", oreq, r1);
        end
        tick();
        oresp = mk_resp(1'b1, 1'b0, 64'h0);
        @(negedge clk);
        n_checks++;
        if (oreq.data !== 64'h1111 || iresps[1].ready !== 1'b1 || iresps[0] !== '0) begin
            n_fail++; $display("FAIL wr_beat0: data %h rdy1 %b resp0 %h want 1111/1/0",
                               oreq.data, iresps[1].ready, iresps[0]);
        end
        tick();
        r1.data  = 64'h2222;
        ireqs[1] = r1;
        oresp    = mk_resp(1'b1, 1'b1, 64'h0);
        @(negedge clk);
        n_checks++;
        if (oreq !== r1) begin
            n_fail++; $display("FAIL wr_beat1: got %h want %h", oreq, r1);
        end
        tick();
        ireqs[1] = '0;
        oresp    = '0;
        @(negedge clk);
        n_checks++;
        if (oreq.valid !== 1'b0) begin
            n_fail++; $display("FAIL wr_gap: got %b want 0", oreq.valid);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (oreq !== r0) begin
            n_fail++; $display("FAIL wr_next_m0: got %h want %h", oreq, r0);
        end
        oresp = mk_resp(1'b1, 1'b1, 64'h0);
        tick();
        ireqs = '0;
        oresp = '0;
    endtask

    task automatic test_single_beat();
        cbus_req_t r0, r1;
        r0 = mk_req(1'b1, 1'b0, 64'h5000, MLEN1, MSIZE4, 8'h00, 64'h0);
        r1 = mk_req(1'b1, 1'b0, 64'h6000, MLEN1, MSIZE4, 8'h00, 64'h0);
        do_reset();
        ireqs[0] = r0;
        ireqs[1] = r1;
        tick();
        oresp = mk_resp(1'b1, 1'b1, 64'h77);
        @(negedge clk);
        n_checks++;
        if (oreq !== r0) begin
            n_fail++; $display("FAIL sb_grant_m0: got %h want %h", oreq, r0);
        end
        tick();
        ireqs[0] = '0;
        oresp    = '0;
        @(negedge clk);
        n_checks++;
        if (oreq.valid !== 1'b0) begin
            n_fail++; $display("FAIL sb_gap: got %b want 0", oreq.valid);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (oreq !== r1) begin
            n_fail++; $display("FAIL sb_grant_m1: got %h want %h", oreq, r1);
        end
        oresp = mk_resp(1'b1, 1'b1, 64'h0);
        tick();
        ireqs = '0;
        oresp = '0;
    endtask

    task automatic test_drop_valid();
        cbus_req_t r0, r0d, r1;
        r0  = mk_req(1'b1, 1'b0, 64'h7000, MLEN4, MSIZE8, 8'h00, 64'h0);
        r1  = mk_req(1'b1, 1'b0, 64'h7100, MLEN1, MSIZE8, 8'h00, 64'h0);
        r0d = r0;
        r0d.valid = 1'b0;
        do_reset();
        ireqs[0] = r0;
        tick();
        tick();
        ireqs[0] = r0d;
        ireqs[1] = r1;
        @(negedge clk);
        n_checks++;
        if (oreq !== r0d) begin
            n_fail++; $display("FAIL drop_follow: got %h want %h", oreq, r0d);
        end
        tick();
        oresp = mk_resp(1'b1, 1'b1, 64'h99);
        @(negedge clk);
        n_checks++;
        if (iresps[0] !== mk_resp(1'b1, 1'b1, 64'h99) || iresps[1] !== '0) begin
            n_fail++; $display("FAIL drop_resp: got %h want m0 beat only", iresps);
        end
        tick();
        ireqs[0] = '0;
        oresp    = '0;
        @(negedge clk);
        n_checks++;
        if (oreq.valid !== 1'b0) begin
            n_fail++; $display("FAIL drop_gap: got %b want 0", oreq.valid);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (oreq !== r1) begin
            n_fail++; $display("FAIL drop_next_m1: got %h want %h", oreq, r1);
        end
        oresp = mk_resp(1'b1, 1'b1, 64'h0);
        tick();
        ireqs = '0;
        oresp = '0;
    endtask

    task automatic test_reset_mid_busy();
        cbus_req_t r0, r1;
        r0 = mk_req(1'b1, 1'b0, 64'h9000, MLEN1, MSIZE8, 8'h00, 64'h0);
        r1 = mk_req(1'b1, 1'b0, 64'hA000, MLEN4, MSIZE8, 8'h00, 64'h0);
        do_reset();
        ireqs[1] = r1;
        tick();
        oresp = mk_resp(1'b1, 1'b0, 64'h1);
        @(negedge clk);
        n_checks++;
        if (oreq !== r1) begin
            n_fail++; $display("FAIL rst_busy_m1: got %h want %h", oreq, r1);
        end
        tick();
        oresp = mk_resp(1'b1, 1'b0, 64'h2);
        tick();
        reset = 1'b1;
        oresp = mk_resp(1'b1, 1'b0, 64'h3);
        @(negedge clk);
        n_checks++;
        if (oreq !== '0 || iresps !== '0) begin
            n_fail++; $display("FAIL rst_mid_out: oreq %h iresps %h want 0", oreq, iresps);
        end
        tick();
        reset    = 1'b0;
        oresp    = '0;
        ireqs[0] = r0;
        @(negedge clk);
        n_checks++;
        if (oreq !== '0 || iresps !== '0) begin
            n_fail++; $display("FAIL rst_after_idle: oreq %h iresps %h want 0", oreq, iresps);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (oreq !== r0) begin
            n_fail++; $display("FAIL rst_after_m0: got %h want %h", oreq, r0);
        end
        oresp = mk_resp(1'b1, 1'b1, 64'h0);
        tick();
        ireqs = '0;
        oresp = '0;
    endtask

    task automatic test_idle_ready();
        cbus_req_t r0, r1;
        r0 = mk_req(1'b1, 1'b0, 64'hB000, MLEN1, MSIZE8, 8'h00, 64'h0);
        r1 = mk_req(1'b1, 1'b0, 64'hC000, MLEN1, MSIZE8, 8'h00, 64'h0);
        do_reset();
        oresp = mk_resp(1'b1, 1'b1, 64'hDEAD);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (iresps !== '0 || oreq !== '0) begin
                n_fail++; $display("FAIL idle_rdy_c%0d: iresps %h oreq %h want 0", c, iresps, oreq);
            end
            tick();
        end
        oresp    = '0;
        ireqs[0] = r0;
        ireqs[1] = r1;
        tick();
        @(negedge clk);
        n_checks++;
        if (oreq !== r0) begin
            n_fail++; $display("FAIL idle_rdy_prio: got %h want %h", oreq, r0);
        end
        oresp = mk_resp(1'b1, 1'b1, 64'h0);
        tick();
        ireqs = '0;
        oresp = '0;
    endtask

    initial begin
        reset = 1'b1;
        ireqs = '0;
        oresp = '0;
        test_reset();
        test_read_burst();
        test_round_robin();
        test_back_to_back_write();
        test_single_beat();
        test_drop_valid();
        test_reset_mid_busy();
        test_idle_ready();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
